// File: rtl/lcd_sync_module_if.sv
// LCD panel timing bundle: sync strobes, data-enable and pixel coordinates.
interface lcd_sync_module_if;
  logic        lcd_hsync;
  logic        lcd_vsync;
  logic        ready_sig;
  logic [10:0] column_addr_sig;
  logic [10:0] row_addr_sig;
  logic        frame_start_sig;

  modport master (
    output lcd_hsync,
    output lcd_vsync,
    output ready_sig,
    output column_addr_sig,
    output row_addr_sig,
    output frame_start_sig
  );

  modport slave (
    input lcd_hsync,
    input lcd_vsync,
    input ready_sig,
    input column_addr_sig,
    input row_addr_sig,
    input frame_start_sig
  );
endinterface

// File: rtl/lcd_sync_module.sv
// RGB LCD timing generator. Free-running h/v counters; every output is a
// registered decode of the counter values held before the edge, so the
// data-enable and the coordinates always describe the same pixel.
module lcd_sync_module #(
  parameter int H_SYNC   = 1,
  parameter int H_BACK   = 46,
  parameter int H_DISP   = 800,
  parameter int H_FRONT  = 210,
  parameter int V_SYNC   = 1,
  parameter int V_BACK   = 23,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 22,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  lcd_sync_module_if.master  lcd
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_E  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_E  = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] V_ACT_BEG = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_END = 11'(V_SYNC + V_BACK + V_DISP);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        ready_q, ready_d;
  logic [10:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic        fs_q, fs_d;

  logic h_last, v_last, h_act, v_act;

  // Counter advance: v steps only on the last pixel of a line, both wrap together.
  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  // Output decode of the current counters; registered below for 1-clk latency.
  always_comb begin
    h_act   = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
    v_act   = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    hsync_d = (h_cnt_q < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_cnt_q < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    ready_d = h_act && v_act;
    col_d   = '0;
    row_d   = '0;
    if (ready_d) begin
      col_d = h_cnt_q - H_ACT_BEG;
      row_d = v_cnt_q - V_ACT_BEG;
    end
    fs_d = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
  end

  // State and output registers; reset parks syncs at their inactive level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      ready_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ready_q <= ready_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fs_q    <= fs_d;
    end
  end

  assign lcd.lcd_hsync       = hsync_q;
  assign lcd.lcd_vsync       = vsync_q;
  assign lcd.ready_sig       = ready_q;
  assign lcd.column_addr_sig = col_q;
  assign lcd.row_addr_sig    = row_q;
  assign lcd.frame_start_sig = fs_q;

endmodule

// File: tb/tb_lcd_sync_module.sv
// Scoreboard bench for lcd_sync_module with a small 15x8 timing.
module tb_lcd_sync_module;

  localparam int HT = 15;
  localparam int VT = 8;

  logic clk;
  logic rstn;

  lcd_sync_module_if lcd_if ();

  lcd_sync_module #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
    .SYNC_POL(1'b0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .lcd  (lcd_if)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        rdy;
    logic [10:0] col;
    logic [10:0] row;
    logic        fs;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  int fs_cnt = 0;
  int max_col = 0;
  int max_row = 0;
  int cyc = 0;
  int fs_last = 0;
  bit fs_prev_ok = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the t-th edge after reset release (counter value t).
  function automatic exp_t model(input int t);
    exp_t e;
    int h, v;
    bit act;
    h = t % HT;
    v = (t / HT) % VT;
    act = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
    e.hs  = (h < 2) ? 1'b0 : 1'b1;
    e.vs  = (v < 1) ? 1'b0 : 1'b1;
    e.rdy = act;
    e.col = act ? 11'(h - 5) : 11'd0;
    e.row = act ? 11'(v - 3) : 11'd0;
    e.fs  = ((t % (HT * VT)) == 0);
    return e;
  endfunction

  function automatic exp_t rst_vec();
    exp_t e;
    e.hs = 1'b1; e.vs = 1'b1; e.rdy = 1'b0;
    e.col = '0;  e.row = '0;  e.fs = 1'b0;
    return e;
  endfunction

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare with what the DUT shows.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.hs  = lcd_if.lcd_hsync;
        g.vs  = lcd_if.lcd_vsync;
        g.rdy = lcd_if.ready_sig;
        g.col = lcd_if.column_addr_sig;
        g.row = lcd_if.row_addr_sig;
        g.fs  = lcd_if.frame_start_sig;
        n_vec++;
        if (g !== e) begin
          n_err++;
          $display("FAIL vec cyc%0d: got hs=%b vs=%b rdy=%b col=%0d row=%0d fs=%b want hs=%b vs=%b rdy=%b col=%0d row=%0d fs=%b",
                   cyc, g.hs, g.vs, g.rdy, g.col, g.row, g.fs,
                   e.hs, e.vs, e.rdy, e.col, e.row, e.fs);
        end
        if (!rstn) fs_prev_ok = 0;
        if (g.rdy === 1'b1) begin
          rdy_cnt++;
          if (int'(g.col) > max_col) max_col = int'(g.col);
          if (int'(g.row) > max_row) max_row = int'(g.row);
        end
        if (g.fs === 1'b1) begin
          fs_cnt++;
          if (fs_prev_ok) check_int("frame_period", cyc - fs_last, HT * VT);
          fs_last = cyc;
          fs_prev_ok = 1;
        end
        cyc++;
      end
    end
  end

  // Stimulus: reset, three-plus frames, async reset mid-pixel, two more frames.
  initial begin
    rstn = 1'b0;
    repeat (10) begin
      @(posedge clk);
      exp_q.push_back(rst_vec());
    end
    @(negedge clk);
    rstn = 1'b1;

    // t=415 is frame 4, line 3, h=10 -> column 5; reset hits during that pixel.
    for (int t = 0; t < 415; t++) begin
      @(posedge clk);
      exp_q.push_back(model(t));
    end
    @(posedge clk);
    #2;
    rstn = 1'b0;
    exp_q.push_back(rst_vec());
    repeat (4) begin
      @(posedge clk);
      exp_q.push_back(rst_vec());
    end
    @(negedge clk);
    rstn = 1'b1;

    for (int t = 0; t < 2 * HT * VT; t++) begin
      @(posedge clk);
      exp_q.push_back(model(t));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);

    // 3 full frames (96) + 5 pixels before the async reset + 2 frames (64).
    check_int("active_count", rdy_cnt, 165);
    check_int("max_column", max_col, 7);
    check_int("max_row", max_row, 3);
    check_int("frame_starts", fs_cnt, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
